// File: rtl/uart_frame_loader_pkg.sv
// Shared constants and state encoding for the UART-to-frame-buffer loader.
package uart_frame_loader_pkg;

  localparam int unsigned DEF_FRAME_BYTES = 76800;
  localparam int unsigned DEF_ADDR_W      = 17;
  localparam int unsigned DEF_TIMEOUT_CYC = 1000000;
  localparam int unsigned DEF_RD_WAIT_MAX = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REQ,
    ST_RWAIT,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

  // Width of a counter that must be able to hold the value 'limit'.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/uart_frame_loader_if.sv
// Receive-FIFO read side and frame-buffer RAM write port as seen by the loader.
interface uart_frame_loader_if #(
  parameter int unsigned ADDR_W = uart_frame_loader_pkg::DEF_ADDR_W
);

  logic              rx_empty_i;
  logic              rx_full_i;
  logic [7:0]        rx_data_i;
  logic              rd_valid_i;
  logic              rx_active_o;
  logic              rd_en_o;
  logic              ram_en_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [7:0]        ram_data_o;

  modport master (
    input  rx_empty_i, rx_full_i, rx_data_i, rd_valid_i,
    output rx_active_o, rd_en_o, ram_en_o, ram_we_o, ram_addr_o, ram_data_o
  );

  modport slave (
    output rx_empty_i, rx_full_i, rx_data_i, rd_valid_i,
    input  rx_active_o, rd_en_o, ram_en_o, ram_we_o, ram_addr_o, ram_data_o
  );

endinterface

// File: rtl/uart_frame_loader_gap_timer.sv
// Saturating cycle counter with synchronous clear; expired_o flags that LIMIT
// enabled cycles have elapsed since the last clear.
module uart_frame_loader_gap_timer
  import uart_frame_loader_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_RD_WAIT_MAX
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned       CW      = cnt_width(LIMIT);
  localparam logic [CW-1:0]     LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: cnt_d is assigned before any branch so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/uart_frame_loader.sv
// Drains bytes from the UART receive FIFO into the frame-buffer RAM until one
// frame is stored, with gap timeout, read-wait timeout, checksum and overrun flag.
module uart_frame_loader
  import uart_frame_loader_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = DEF_FRAME_BYTES,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned RD_WAIT_MAX = DEF_RD_WAIT_MAX
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  uart_frame_loader_if.master bus,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic                ovf_o,
  output logic [ADDR_W:0]     byte_cnt_o,
  output logic [7:0]          checksum_o
);

  localparam logic [ADDR_W:0] FRAME_CNT = (ADDR_W + 1)'(FRAME_BYTES);

  loader_state_e     state_q, state_d;
  logic [ADDR_W:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]        checksum_q, checksum_d;
  logic [7:0]        data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;

  logic busy;
  logic gap_clr, gap_en, gap_expired;
  logic rd_clr, rd_cnt_en, rd_expired;

  assign busy = (state_q == ST_WAIT) || (state_q == ST_REQ) ||
                (state_q == ST_RWAIT) || (state_q == ST_WRITE);

  // Inter-byte gap only counts in WAIT once the frame has started.
  assign gap_en    = (state_q == ST_WAIT) && (byte_cnt_q != '0);
  assign rd_clr    = (state_q != ST_RWAIT);
  assign rd_cnt_en = (state_q == ST_RWAIT);

  uart_frame_loader_gap_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_gap_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (gap_clr),
    .en_i      (gap_en),
    .expired_o (gap_expired)
  );

  uart_frame_loader_gap_timer #(
    .LIMIT (RD_WAIT_MAX)
  ) u_rd_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (rd_clr),
    .en_i      (rd_cnt_en),
    .expired_o (rd_expired)
  );

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    checksum_d = checksum_q;
    data_d     = data_q;
    addr_d     = addr_q;
    done_d     = done_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    gap_clr    = 1'b0;

    if (busy && bus.rx_full_i) begin
      ovf_d = 1'b1;
    end

    // Abort overrides every transition, including a pending write commit.
    if (abort_i) begin
      state_d = ST_IDLE;
      gap_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d    = ST_WAIT;
            byte_cnt_d = '0;
            checksum_d = '0;
            done_d     = 1'b0;
            err_d      = 1'b0;
            ovf_d      = 1'b0;
            gap_clr    = 1'b1;
          end
        end
        ST_WAIT: begin
          if (!bus.rx_empty_i) begin
            state_d = ST_REQ;
          end else if ((byte_cnt_q != '0) && gap_expired) begin
            state_d = ST_ERROR;
          end
        end
        ST_REQ: begin
          state_d = ST_RWAIT;
        end
        ST_RWAIT: begin
          if (bus.rd_valid_i) begin
            data_d  = bus.rx_data_i;
            addr_d  = byte_cnt_q[ADDR_W-1:0];
            state_d = ST_WRITE;
          end else if (rd_expired) begin
            state_d = ST_ERROR;
          end
        end
        ST_WRITE: begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          checksum_d = checksum_q + data_q;
          gap_clr    = 1'b1;
          state_d    = (byte_cnt_d == FRAME_CNT) ? ST_DONE : ST_WAIT;
        end
        ST_DONE: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_ERROR: begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      checksum_q <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      checksum_q <= checksum_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.rx_active_o = busy;
  assign bus.rd_en_o     = (state_q == ST_REQ) && !abort_i;
  assign bus.ram_en_o    = (state_q == ST_WRITE) && !abort_i;
  assign bus.ram_we_o    = (state_q == ST_WRITE) && !abort_i;
  assign bus.ram_addr_o  = addr_q;
  assign bus.ram_data_o  = data_q;

  assign busy_o     = busy;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign ovf_o      = ovf_q;
  assign byte_cnt_o = byte_cnt_q;
  assign checksum_o = checksum_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader with a 16-byte frame and short timeouts.
module tb_uart_frame_loader;

  localparam int unsigned FRAME_BYTES = 16;
  localparam int unsigned ADDR_W      = 4;
  localparam int unsigned TIMEOUT_CYC = 100;
  localparam int unsigned RD_WAIT_MAX = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;
  logic busy, done, err, ovf;
  logic [ADDR_W:0] byte_cnt;
  logic [7:0]      checksum;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]        fifo_q[$];
  wr_t               exp_q[$];
  logic [ADDR_W-1:0] exp_addr;
  logic              rd_mute;
  wr_t               mon_e;
  logic [7:0]        resp_byte;

  uart_frame_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_frame_loader #(
    .FRAME_BYTES (FRAME_BYTES),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .RD_WAIT_MAX (RD_WAIT_MAX)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .abort_i    (abort),
    .bus        (bus),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .ovf_o      (ovf),
    .byte_cnt_o (byte_cnt),
    .checksum_o (checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start    = 1'b1;
    exp_addr = '0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic pulse_full();
    @(posedge clk); #1;
    bus.rx_full_i = 1'b1;
    @(posedge clk); #1;
    bus.rx_full_i = 1'b0;
  endtask

  // Queue a byte in the host FIFO; when it will be written, expect the RAM write.
  task automatic push(input logic [7:0] b, input bit expect_wr);
    fifo_q.push_back(b);
    if (expect_wr) begin
      exp_q.push_back('{addr: exp_addr, data: b});
      exp_addr = exp_addr + 1'b1;
    end
  endtask

  task automatic wait_cnt(input int n, input int budget, input string tag);
    int k = 0;
    @(negedge clk);
    while ((int'(byte_cnt) != n) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(byte_cnt), n);
  endtask

  task automatic wait_end(input int budget, input string tag);
    int k = 0;
    @(negedge clk);
    while (!(done || err) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(done | err), 1);
  endtask

  // FIFO model: answers each read request with a one-cycle rd_valid pulse.
  initial begin
    bus.rx_empty_i = 1'b1;
    bus.rd_valid_i = 1'b0;
    bus.rx_data_i  = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.rd_en_o && (fifo_q.size() > 0)) begin
        resp_byte      = fifo_q.pop_front();
        bus.rx_empty_i = (fifo_q.size() == 0);
        if (!rd_mute) begin
          @(posedge clk); #1;
          bus.rd_valid_i = 1'b1;
          bus.rx_data_i  = resp_byte;
          @(posedge clk); #1;
          bus.rd_valid_i = 1'b0;
        end
      end else begin
        bus.rx_empty_i = (fifo_q.size() == 0);
      end
    end
  end

  // Monitor: every RAM write must match the next expected (addr, data).
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.ram_en_o && bus.ram_we_o) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                   bus.ram_addr_o, bus.ram_data_o);
        end else begin
          mon_e = exp_q.pop_front();
          check("ram_addr", 32'(bus.ram_addr_o), 32'(mon_e.addr));
          check("ram_data", 32'(bus.ram_data_o), 32'(mon_e.data));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    abort         = 1'b0;
    rd_mute       = 1'b0;
    exp_addr      = '0;
    bus.rx_full_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_cnt", 32'(byte_cnt), 0);
    check("rst_sum", 32'(checksum), 0);
    check("rst_rx_active", 32'(bus.rx_active_o), 0);
    check("rst_rd_en", 32'(bus.rd_en_o), 0);
    check("rst_ram_en", 32'(bus.ram_en_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: bytes 0x00..0x0F fill the frame
    do_start();
    check("t1_busy", 32'(busy), 1);
    check("t1_rx_active", 32'(bus.rx_active_o), 1);
    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    wait_end(400, "t1_end");
    check("t1_done", 32'(done), 1);
    check("t1_err", 32'(err), 0);
    check("t1_busy_off", 32'(busy), 0);
    check("t1_rx_active_off", 32'(bus.rx_active_o), 0);
    check("t1_cnt", 32'(byte_cnt), 16);
    check("t1_sum", 32'(checksum), 32'h78);
    check("t1_addr_hold", 32'(bus.ram_addr_o), 32'hF);
    check("t1_ram_en_off", 32'(bus.ram_en_o), 0);
    check("t1_writes_left", 32'(exp_q.size()), 0);

    // 2: five bytes then stall -> gap timeout
    do_start();
    check("t2_done_clr", 32'(done), 0);
    for (int i = 0; i < 5; i++) push(8'(8'hA0 + i), 1'b1);
    wait_cnt(5, 200, "t2_cnt5");
    repeat (95) @(negedge clk);
    check("t2_no_early_err", 32'(err), 0);
    check("t2_still_busy", 32'(busy), 1);
    wait_end(30, "t2_end");
    check("t2_err", 32'(err), 1);
    check("t2_done", 32'(done), 0);
    check("t2_busy", 32'(busy), 0);
    check("t2_cnt", 32'(byte_cnt), 5);
    check("t2_sum", 32'(checksum), 32'h2A);

    // 3: long idle before the first byte is not a timeout
    do_start();
    check("t3_err_clr", 32'(err), 0);
    repeat (10 * TIMEOUT_CYC) @(negedge clk);
    check("t3_busy", 32'(busy), 1);
    check("t3_err", 32'(err), 0);
    check("t3_cnt0", 32'(byte_cnt), 0);
    for (int i = 0; i < 16; i++) push(8'(i * 17), 1'b1);
    wait_end(400, "t3_end");
    check("t3_done", 32'(done), 1);
    check("t3_cnt", 32'(byte_cnt), 16);
    check("t3_sum", 32'(checksum), 32'hF8);

    // 4: abort after 7 bytes, then a clean frame
    do_start();
    for (int i = 0; i < 7; i++) push(8'h55, 1'b1);
    wait_cnt(7, 200, "t4_cnt7");
    pulse_abort();
    @(negedge clk);
    check("t4_abort_busy", 32'(busy), 0);
    check("t4_abort_done", 32'(done), 0);
    check("t4_abort_err", 32'(err), 0);
    do_start();
    for (int i = 0; i < 16; i++) push(8'h01, 1'b1);
    wait_end(400, "t4_end");
    check("t4_done", 32'(done), 1);
    check("t4_cnt", 32'(byte_cnt), 16);
    check("t4_sum", 32'(checksum), 32'h10);

    // 5: read request never answered -> error; overrun flag
    do_start();
    rd_mute = 1'b1;
    push(8'h77, 1'b0);
    wait_end(50, "t5_end");
    check("t5_err", 32'(err), 1);
    check("t5_cnt", 32'(byte_cnt), 0);
    check("t5_busy", 32'(busy), 0);
    rd_mute = 1'b0;
    pulse_full();
    @(negedge clk);
    check("t5_ovf_idle", 32'(ovf), 0);
    do_start();
    check("t5_err_clr", 32'(err), 0);
    pulse_full();
    @(negedge clk);
    check("t5_ovf_set", 32'(ovf), 1);
    repeat (5) @(negedge clk);
    check("t5_ovf_sticky", 32'(ovf), 1);
    check("t5_ovf_busy", 32'(busy), 1);
    pulse_abort();
    @(negedge clk);
    check("t5_ovf_after_abort", 32'(ovf), 1);
    do_start();
    check("t5_ovf_clr", 32'(ovf), 0);
    pulse_abort();

    // 6: reset mid-frame, then start ignored while busy
    do_start();
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    wait_cnt(3, 100, "t6_cnt3");
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_cnt", 32'(byte_cnt), 0);
    check("t6_rst_sum", 32'(checksum), 0);
    check("t6_rst_rx_active", 32'(bus.rx_active_o), 0);
    check("t6_rst_addr", 32'(bus.ram_addr_o), 0);
    check("t6_rst_data", 32'(bus.ram_data_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_start();
    for (int i = 0; i < 16; i++) push(8'hFF, 1'b1);
    wait_cnt(4, 100, "t6_cnt4");
    pulse_start();
    wait_end(400, "t6_end");
    check("t6_done", 32'(done), 1);
    check("t6_busy", 32'(busy), 0);
    check("t6_cnt", 32'(byte_cnt), 16);
    check("t6_sum", 32'(checksum), 32'hF0);
    repeat (10) @(negedge clk);
    check("t6_writes_left", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
